updown_hex_counter: RTL

Button front-end feeding the seven-segment display controller. Synchronises and debounces raw `up`/`down` pushbuttons and converts presses (plus optional hold-to-repeat) into wrap-around steps of a 4-bit hex value. The controller decodes that value into segments. An `enable` input gates counting without stopping input conditioning.

---
 rtl/updown_hex_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/updown_hex_counter.sv
// rtl/updown_hex_counter.sv - synchronised, debounced up/down buttons driving a wrap-around hex counter
module updown_hex_counter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0,
  parameter int WIDTH           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             changed,
  output logic             up_db,
  output logic             down_db
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] db;
  logic [1:0] press;
  logic [1:0] rpt;
  logic       ev_up;
  logic       ev_dn;

  // bit 0 is the up button, bit 1 the down button
  assign raw = {down, up};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [DW-1:0] dcnt;
    logic          db_r;
    logic          flip;

    assign flip     = (sync2[b] != db_r) && (dcnt == DB_LAST);
    assign press[b] = flip && sync2[b];
    assign db[b]    = db_r;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dcnt <= '0;
        db_r <= 1'b0;
      end else if (sync2[b] == db_r) begin
        dcnt <= '0;
      end else if (flip) begin
        db_r <= sync2[b];
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end

    if (REPEAT_CYCLES > 0) begin : g_rep
      localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
      localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);
      logic [RW-1:0] rtim;

      assign rpt[b] = db_r && (rtim == RP_LAST);

      // a press always lands while db_r is still 0, so this also clears on press
      always_ff @(posedge clk) begin
        if (!rst_n || !db_r || rpt[b]) begin
          rtim <= '0;
        end else begin
          rtim <= rtim + RW'(1);
        end
      end
    end else begin : g_norep
      assign rpt[b] = 1'b0;
    end
  end

  assign ev_up = press[0] | rpt[0];
  assign ev_dn = press[1] | rpt[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (enable && (ev_up ^ ev_dn)) begin
        count   <= ev_up ? count + WIDTH'(1) : count - WIDTH'(1);
        changed <= 1'b1;
      end
    end
  end

  assign up_db   = db[0];
  assign down_db = db[1];

endmodule
